// File: rtl/nt_release_scheduler.sv
// Rate-limited round-robin arbiter that turns per-regulator inc/dec/fast requests
// into single pulses on a shared neurotransmitter level, with a refractory window after fast steps.
module nt_release_scheduler #(
  parameter int N_REQ         = 4,
  parameter int N             = 6,
  parameter int TICK_DIV      = 8,
  parameter int REFRACT_TICKS = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req_inc,
  input  logic [N_REQ-1:0] req_dec,
  input  logic [N_REQ-1:0] req_fast,
  input  logic             force_set,
  input  logic [N-1:0]     level,
  output logic             inc,
  output logic             dec,
  output logic             fast,
  output logic             setval,
  output logic [N_REQ-1:0] grant,
  output logic             busy
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(TICK_DIV);
  localparam int RW = $clog2(REFRACT_TICKS + 1);
  localparam logic [N-1:0] LVL_MAX = '1;

  typedef enum logic {IDLE, REFRACT} state_t;

  state_t            state_q;
  logic [CW-1:0]     cnt_q;
  logic [RW-1:0]     rcnt_q;
  logic [PW-1:0]     rr_ptr_q;
  logic              inc_q, dec_q, fast_q, setval_q, busy_q;
  logic [N_REQ-1:0]  grant_q;

  logic              tick_d;
  logic [N_REQ-1:0]  elig_d;
  logic              hit_d;
  logic [PW-1:0]     sel_d;
  logic [N_REQ-1:0]  gnt_d;
  logic              dir_inc_d;
  logic              fast_d;
  logic [PW-1:0]     rr_next_d;
  int                idx;

  assign tick_d = (cnt_q == CW'(TICK_DIV - 1));

  // A saturated direction is treated as not requesting, so the search skips it.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      elig_d[i] = (req_inc[i] ^ req_dec[i]) &&
                  (req_inc[i] ? (level != LVL_MAX) : (level != '0));
    end
  end

  always_comb begin
    hit_d     = 1'b0;
    sel_d     = '0;
    gnt_d     = '0;
    dir_inc_d = 1'b0;
    fast_d    = 1'b0;
    idx       = 0;
    for (int off = 0; off < N_REQ; off++) begin
      idx = int'(rr_ptr_q) + off;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!hit_d && elig_d[idx]) begin
        hit_d      = 1'b1;
        sel_d      = PW'(idx);
        gnt_d[idx] = 1'b1;
        dir_inc_d  = req_inc[idx];
        fast_d     = req_fast[idx];
      end
    end
    rr_next_d = (sel_d == PW'(N_REQ - 1)) ? '0 : sel_d + PW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rcnt_q   <= '0;
      rr_ptr_q <= '0;
      inc_q    <= 1'b0;
      dec_q    <= 1'b0;
      fast_q   <= 1'b0;
      setval_q <= 1'b0;
      busy_q   <= 1'b0;
      grant_q  <= '0;
    end else begin
      cnt_q    <= tick_d ? '0 : cnt_q + CW'(1);
      inc_q    <= 1'b0;
      dec_q    <= 1'b0;
      fast_q   <= 1'b0;
      setval_q <= 1'b0;
      grant_q  <= '0;
      // force_set overrides any decision this cycle and leaves the prescaler alone.
      if (force_set) begin
        setval_q <= 1'b1;
        state_q  <= IDLE;
        busy_q   <= 1'b0;
        rcnt_q   <= '0;
      end else if (tick_d) begin
        case (state_q)
          IDLE: begin
            if (hit_d) begin
              grant_q  <= gnt_d;
              inc_q    <= dir_inc_d;
              dec_q    <= !dir_inc_d;
              fast_q   <= fast_d;
              rr_ptr_q <= rr_next_d;
              if (fast_d) begin
                state_q <= REFRACT;
                busy_q  <= 1'b1;
                rcnt_q  <= '0;
              end
            end
          end
          REFRACT: begin
            if (rcnt_q == RW'(REFRACT_TICKS - 1)) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              rcnt_q  <= '0;
            end else begin
              rcnt_q <= rcnt_q + RW'(1);
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign inc    = inc_q;
  assign dec    = dec_q;
  assign fast   = fast_q;
  assign setval = setval_q;
  assign grant  = grant_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_nt_release_scheduler.sv
// Directed and randomized bench for nt_release_scheduler against a tick/refractory-count reference model.
module tb_nt_release_scheduler;

  localparam int N_REQ         = 4;
  localparam int N             = 6;
  localparam int TICK_DIV      = 8;
  localparam int REFRACT_TICKS = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N_REQ-1:0] req_inc, req_dec, req_fast;
  logic             force_set;
  logic [N-1:0]     level;
  logic             inc, dec, fast, setval, busy;
  logic [N_REQ-1:0] grant;

  int checks = 0;
  int errors = 0;

  // reference model state
  int edge_cnt;
  int rr;
  int refr_left;
  logic             e_inc, e_dec, e_fast, e_setval, e_busy;
  logic [N_REQ-1:0] e_grant;
  int pulses;

  nt_release_scheduler #(
    .N_REQ(N_REQ), .N(N), .TICK_DIV(TICK_DIV), .REFRACT_TICKS(REFRACT_TICKS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_inc(req_inc), .req_dec(req_dec),
    .req_fast(req_fast), .force_set(force_set), .level(level),
    .inc(inc), .dec(dec), .fast(fast), .setval(setval), .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    edge_cnt  = 0;
    rr        = 0;
    refr_left = 0;
    e_inc = 0; e_dec = 0; e_fast = 0; e_setval = 0; e_busy = 0; e_grant = '0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".inc"},    32'(inc),    32'(e_inc));
    check({tag, ".dec"},    32'(dec),    32'(e_dec));
    check({tag, ".fast"},   32'(fast),   32'(e_fast));
    check({tag, ".setval"}, 32'(setval), 32'(e_setval));
    check({tag, ".grant"},  32'(grant),  32'(e_grant));
    check({tag, ".busy"},   32'(busy),   32'(e_busy));
  endtask

  // Predict the outputs after the coming edge, then clock and compare.
  task automatic step(input string tag);
    bit is_tick;
    bit found;
    int k;
    bit ok;
    is_tick = ((edge_cnt + 1) % TICK_DIV) == 0;
    e_inc = 0; e_dec = 0; e_fast = 0; e_setval = 0; e_grant = '0;
    if (force_set) begin
      e_setval  = 1;
      refr_left = 0;
    end else if (is_tick) begin
      if (refr_left > 0) begin
        refr_left--;
      end else begin
        found = 0;
        for (int off = 0; off < N_REQ && !found; off++) begin
          k  = (rr + off) % N_REQ;
          ok = (req_inc[k] != req_dec[k]) &&
               (req_inc[k] ? (int'(level) != (1 << N) - 1) : (int'(level) != 0));
          if (ok) begin
            found      = 1;
            e_grant[k] = 1'b1;
            e_inc      = req_inc[k];
            e_dec      = !req_inc[k];
            e_fast     = req_fast[k];
            rr         = (k + 1) % N_REQ;
            if (req_fast[k]) refr_left = REFRACT_TICKS;
          end
        end
      end
    end
    e_busy = (refr_left > 0);
    edge_cnt++;
    @(posedge clk);
    #1;
    check_all(tag);
    if (inc || dec || setval) pulses++;
  endtask

  task automatic do_reset();
    rst_n = 0;
    req_inc = '0; req_dec = '0; req_fast = '0; force_set = 0; level = 6'd20;
    @(posedge clk);
    #1;
    rst_n = 1;
    model_reset();
    check_all("reset");
  endtask

  initial begin
    rst_n = 1;
    req_inc = '0; req_dec = '0; req_fast = '0; force_set = 0; level = '0;
    #2;
    do_reset();

    // 1: idle for 40 clocks
    pulses = 0;
    for (int i = 0; i < 40; i++) step("idle");
    check("idle_pulses", 32'(pulses), 32'd0);

    // 2: alternating inc grants on requesters 0 and 2
    do_reset();
    req_inc = 4'b0101;
    for (int i = 0; i < 8; i++) step("alt");
    check("alt_first_grant", 32'(grant), 32'h1);
    check("alt_first_inc", 32'(inc), 32'h1);
    for (int i = 0; i < 8; i++) step("alt");
    check("alt_second_grant", 32'(grant), 32'h4);
    for (int i = 0; i < 8; i++) step("alt");
    check("alt_third_grant", 32'(grant), 32'h1);

    // 3: inc and dec together means no request
    do_reset();
    req_inc = 4'b0010; req_dec = 4'b0010;
    pulses = 0;
    for (int i = 0; i < 32; i++) step("both");
    check("both_pulses", 32'(pulses), 32'd0);

    // 4: saturated level drops the request
    do_reset();
    req_inc = 4'b0100; level = 6'd63;
    pulses = 0;
    for (int i = 0; i < 24; i++) step("sat_hi");
    req_inc = '0; req_dec = 4'b1000; level = 6'd0;
    for (int i = 0; i < 24; i++) step("sat_lo");
    check("sat_pulses", 32'(pulses), 32'd0);

    // 5: fast dec, refractory of three ticks
    do_reset();
    req_dec = 4'b0001; req_fast = 4'b0001;
    for (int i = 0; i < 8; i++) step("fast");
    check("fast_dec", 32'(dec), 32'h1);
    check("fast_fast", 32'(fast), 32'h1);
    check("fast_busy", 32'(busy), 32'h1);
    pulses = 0;
    for (int i = 0; i < 31; i++) step("refract");
    check("refract_pulses", 32'(pulses), 32'd0);
    step("refract_end");
    check("refract_next_dec", 32'(dec), 32'h1);

    // 6a: force_set during refractory on a tick
    do_reset();
    req_dec = 4'b0001; req_fast = 4'b0001;
    for (int i = 0; i < 15; i++) step("fs_pre");
    force_set = 1;
    step("fs_tick");
    force_set = 0;
    check("fs_setval", 32'(setval), 32'h1);
    check("fs_busy", 32'(busy), 32'h0);
    check("fs_grant", 32'(grant), 32'h0);
    req_fast = '0; req_dec = 4'b0011;
    for (int i = 0; i < 8; i++) step("fs_after");
    check("fs_rr_after", 32'(grant), 32'h2);

    // 6b: force_set on an idle tick discards the grant without advancing rr_ptr
    do_reset();
    req_inc = 4'b0101;
    for (int i = 0; i < 7; i++) step("fs_idle");
    force_set = 1;
    step("fs_idle_tick");
    force_set = 0;
    check("fs_idle_setval", 32'(setval), 32'h1);
    for (int i = 0; i < 8; i++) step("fs_idle_next");
    check("fs_idle_rr", 32'(grant), 32'h1);

    // 6c: async reset in the middle of a pulse
    do_reset();
    req_inc = 4'b0001; req_fast = 4'b0001;
    for (int i = 0; i < 8; i++) step("arst");
    #1;
    rst_n = 0;
    #1;
    check("arst_inc", 32'(inc), 32'h0);
    check("arst_grant", 32'(grant), 32'h0);
    check("arst_busy", 32'(busy), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1;
    model_reset();
    for (int i = 0; i < 10; i++) step("arst_after");

    // randomized traffic
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if (i % 5 == 0) begin
        req_inc  = N_REQ'($urandom);
        req_dec  = N_REQ'($urandom);
        req_fast = N_REQ'($urandom & $urandom);
        case ($urandom_range(0, 3))
          0: level = 6'd0;
          1: level = 6'd63;
          default: level = N'($urandom);
        endcase
      end
      force_set = ($urandom_range(0, 29) == 0);
      step("rand");
    end
    force_set = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
